// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory access controller.
package mem_access_pkg;

  localparam int ADDR_W    = 10;
  localparam int MEM_BYTES = 1024;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Encoding 2'b11 is treated as a word.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Core request/response channel plus byte-memory port of the access controller.
interface mem_access_ctrl_if;
  import mem_access_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_error;
  logic              mem_write_enable;
  logic [ADDR_W-1:0] mem_address;
  logic [7:0]        mem_data_in;
  logic [7:0]        mem_data_out;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, mem_write_enable, mem_address, mem_data_in
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, mem_write_enable, mem_address, mem_data_in
  );

endinterface

// File: rtl/mem_access_ctrl_load_extend.sv
// Combinational sign/zero extension of assembled little-endian load bytes.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = data_i;
    case (size_i)
      SIZE_B:  result_o = {{24{~uns_i & data_i[7]}}, data_i[7:0]};
      SIZE_H:  result_o = {{16{~uns_i & data_i[15]}}, data_i[15:0]};
      default: result_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences byte/half/word loads and stores as single-byte memory accesses.
// Optional MISALIGN_TRAP_EN rejects misaligned half/word requests with rsp_error.
module mem_access_ctrl
  import mem_access_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  mem_access_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_WRITE = ST_WRITE;
  localparam logic [1:0] S_READ  = ST_READ;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_q, asm_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic              we_q, we_d;
  logic [7:0]        din_q, din_d;

  logic [2:0]  req_nbytes;
  logic        misalign;
  logic [2:0]  cnt_nxt;
  logic [1:0]  rd_idx;
  logic [31:0] ext_data;

  assign req_nbytes = size_to_bytes(bus.req_size);
  assign cnt_nxt    = cnt_q + 3'd1;
  // Byte captured this cycle was addressed one cycle earlier.
  assign rd_idx     = cnt_q[1:0] - 2'd1;

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((req_nbytes == 3'd2) && bus.req_addr[0]) ||
                    ((req_nbytes == 3'd4) && (bus.req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nbytes_d = nbytes_q;
    base_d   = base_q;
    size_d   = size_q;
    uns_d    = uns_q;
    wr_d     = wr_q;
    err_d    = err_q;
    wdata_d  = wdata_q;
    asm_d    = asm_q;
    maddr_d  = maddr_q;
    we_d     = we_q;
    din_d    = din_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          base_d   = bus.req_addr;
          nbytes_d = req_nbytes;
          size_d   = bus.req_size;
          uns_d    = bus.req_unsigned;
          wr_d     = bus.req_write;
          wdata_d  = bus.req_wdata;
          err_d    = misalign;
          asm_d    = '0;
          cnt_d    = '0;
          if (misalign) begin
            state_d = S_DONE;
          end else if (bus.req_write) begin
            state_d = S_WRITE;
            maddr_d = bus.req_addr;
            we_d    = 1'b1;
            din_d   = bus.req_wdata[7:0];
          end else begin
            state_d = S_READ;
            maddr_d = bus.req_addr;
          end
        end
      end
      S_WRITE: begin
        if (cnt_q == nbytes_q - 3'd1) begin
          state_d = S_DONE;
          we_d    = 1'b0;
          din_d   = '0;
        end else begin
          cnt_d   = cnt_nxt;
          maddr_d = base_q + ADDR_W'(cnt_nxt);
          din_d   = wdata_q[{cnt_nxt[1:0], 3'b000} +: 8];
        end
      end
      S_READ: begin
        if (cnt_q != 3'd0) begin
          asm_d[{rd_idx, 3'b000} +: 8] = bus.mem_data_out;
        end
        if (cnt_q == nbytes_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_nxt;
          if (cnt_nxt < nbytes_q) begin
            maddr_d = base_q + ADDR_W'(cnt_nxt);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      nbytes_q <= '0;
      base_q   <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      asm_q    <= '0;
      maddr_q  <= '0;
      we_q     <= 1'b0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nbytes_q <= nbytes_d;
      base_q   <= base_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      asm_q    <= asm_d;
      maddr_q  <= maddr_d;
      we_q     <= we_d;
      din_q    <= din_d;
    end
  end

  load_extend u_load_extend (
    .data_i   (asm_q),
    .size_i   (size_q),
    .uns_i    (uns_q),
    .result_o (ext_data)
  );

  assign bus.req_ready        = (state_q == S_IDLE);
  assign bus.rsp_valid        = (state_q == S_DONE);
  assign bus.rsp_error        = bus.rsp_valid & err_q;
  assign bus.rsp_rdata        = (bus.rsp_valid && !wr_q && !err_q) ? ext_data : 32'd0;
  // The strobe is suppressed in the reset cycle so an aborted store writes nothing further.
  assign bus.mem_write_enable = we_q & ~reset;
  assign bus.mem_address      = maddr_q;
  assign bus.mem_data_in      = din_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a registered-read byte memory model.
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus();

  mem_access_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem [0:MEM_BYTES-1];
  logic       mem_clr = 1'b1;
  logic [7:0] mdo = 8'h00;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
    end else if (bus.mem_write_enable) begin
      mem[bus.mem_address] <= bus.mem_data_in;
    end else begin
      mdo <= mem[bus.mem_address];
    end
  end
  assign bus.mem_data_out = mdo;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;
  exp_t q[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT pulses rsp_valid.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d, expected none", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.name, "_rdata"}, bus.rsp_rdata, e.rdata);
          chk({e.name, "_error"}, {31'd0, bus.rsp_error}, {31'd0, e.err});
          chk({e.name, "_cycle"}, cyc, e.cyc);
        end
      end else if (q.size() != 0 && cyc > q[0].cyc) begin
        exp_t e;
        e = q.pop_front();
        n_chk++;
        n_fail++;
        $display("FAIL %s_missing: got no rsp_valid by cycle %0d, expected at %0d", e.name, cyc, e.cyc);
      end
    end
  end

  task automatic issue(input string nm, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [9:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_ready: got req_ready=0, expected 1 within 50 cycles", nm);
      return;
    end
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    q.push_back('{cyc + lat, exp_rd, exp_err, nm});
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no response, expected one within 50 cycles", nm);
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    mem_clr = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_error", {31'd0, bus.rsp_error}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_write_enable}, 32'd0);
    chk("rst_mem_addr", {22'd0, bus.mem_address}, 32'd0);
    chk("rst_mem_din", {24'd0, bus.mem_data_in}, 32'd0);

    issue("st_w_010", 1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, 32'd0, 1'b0, 5);
    chk("mem_010", {24'd0, mem[10'h010]}, 32'hEF);
    chk("mem_011", {24'd0, mem[10'h011]}, 32'hBE);
    chk("mem_012", {24'd0, mem[10'h012]}, 32'hAD);
    chk("mem_013", {24'd0, mem[10'h013]}, 32'hDE);
    issue("ld_w_010",   1'b0, 2'b10, 1'b0, 10'h010, 32'd0, 32'hDEADBEEF, 1'b0, 6);
    issue("ld_b_012_s", 1'b0, 2'b00, 1'b0, 10'h012, 32'd0, 32'hFFFFFFAD, 1'b0, 3);
    issue("ld_b_012_u", 1'b0, 2'b00, 1'b1, 10'h012, 32'd0, 32'h000000AD, 1'b0, 3);
    issue("ld_h_012_s", 1'b0, 2'b01, 1'b0, 10'h012, 32'd0, 32'hFFFFDEAD, 1'b0, 4);
    issue("ld_h_010_u", 1'b0, 2'b01, 1'b1, 10'h010, 32'd0, 32'h0000BEEF, 1'b0, 4);
    issue("ld_h_010_s", 1'b0, 2'b01, 1'b0, 10'h010, 32'd0, 32'hFFFFBEEF, 1'b0, 4);
    issue("ld_s3_010",  1'b0, 2'b11, 1'b0, 10'h010, 32'd0, 32'hDEADBEEF, 1'b0, 6);

    issue("st_b_020", 1'b1, 2'b00, 1'b0, 10'h020, 32'h5555557F, 32'd0, 1'b0, 2);
    issue("st_h_022", 1'b1, 2'b01, 1'b0, 10'h022, 32'h99991234, 32'd0, 1'b0, 3);
    chk("mem_020", {24'd0, mem[10'h020]}, 32'h7F);
    chk("mem_021", {24'd0, mem[10'h021]}, 32'h00);
    chk("mem_022", {24'd0, mem[10'h022]}, 32'h34);
    chk("mem_023", {24'd0, mem[10'h023]}, 32'h12);
    chk("mem_024", {24'd0, mem[10'h024]}, 32'h00);
    issue("ld_b_020_s", 1'b0, 2'b00, 1'b0, 10'h020, 32'd0, 32'h0000007F, 1'b0, 3);
    issue("ld_h_022_s", 1'b0, 2'b01, 1'b0, 10'h022, 32'd0, 32'h00001234, 1'b0, 4);
    issue("ld_w_020",   1'b0, 2'b10, 1'b0, 10'h020, 32'd0, 32'h1234007F, 1'b0, 6);

`ifdef MISALIGN_TRAP_EN
    issue("st_w_3fe", 1'b1, 2'b10, 1'b0, 10'h3FE, 32'h11223344, 32'd0, 1'b1, 1);
    chk("mem_3fe", {24'd0, mem[10'h3FE]}, 32'h00);
    chk("mem_3ff", {24'd0, mem[10'h3FF]}, 32'h00);
    chk("mem_000", {24'd0, mem[10'h000]}, 32'h00);
    chk("mem_001", {24'd0, mem[10'h001]}, 32'h00);
    issue("ld_h_011", 1'b0, 2'b01, 1'b0, 10'h011, 32'd0, 32'd0, 1'b1, 1);
    issue("ld_w_3fe", 1'b0, 2'b10, 1'b0, 10'h3FE, 32'd0, 32'd0, 1'b1, 1);
`else
    issue("st_w_3fe", 1'b1, 2'b10, 1'b0, 10'h3FE, 32'h11223344, 32'd0, 1'b0, 5);
    chk("mem_3fe", {24'd0, mem[10'h3FE]}, 32'h44);
    chk("mem_3ff", {24'd0, mem[10'h3FF]}, 32'h33);
    chk("mem_000", {24'd0, mem[10'h000]}, 32'h22);
    chk("mem_001", {24'd0, mem[10'h001]}, 32'h11);
    issue("ld_h_011", 1'b0, 2'b01, 1'b1, 10'h011, 32'd0, 32'h0000ADBE, 1'b0, 4);
    issue("ld_w_3fe", 1'b0, 2'b10, 1'b0, 10'h3FE, 32'd0, 32'h11223344, 1'b0, 6);
`endif

    // Reset during the second byte of a word store.
    @(negedge clk);
    chk("abort_ready_pre", {31'd0, bus.req_ready}, 32'd1);
    bus.req_write    = 1'b1;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 10'h100;
    bus.req_wdata    = 32'hA1B2C3D4;
    bus.req_valid    = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_c1_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("abort_c1_we", {31'd0, bus.mem_write_enable}, 32'd1);
    chk("abort_c1_addr", {22'd0, bus.mem_address}, 32'h100);
    chk("abort_c1_din", {24'd0, bus.mem_data_in}, 32'hD4);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_c2_we", {31'd0, bus.mem_write_enable}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_ready_post", {31'd0, bus.req_ready}, 32'd1);
    chk("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("abort_mem_100", {24'd0, mem[10'h100]}, 32'hD4);
    chk("abort_mem_101", {24'd0, mem[10'h101]}, 32'h00);
    repeat (6) @(negedge clk);
    issue("ld_b_100_u", 1'b0, 2'b00, 1'b1, 10'h100, 32'd0, 32'h000000D4, 1'b0, 3);
    issue("ld_w_100",   1'b0, 2'b10, 1'b0, 10'h100, 32'd0, 32'h000000D4, 1'b0, 6);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Initiator-side controller for the 1 KiB byte-wide synchronous memory. It accepts byte, half-word and word load/store requests from the core over a valid/ready handshake, and sequences them as little-endian single-byte accesses on the memory port. It assembles and extends load data, and returns a one-cycle response pulse. It sits between the core's load/store path and the byte memory.

## Interface
- ADDR_W, 10, byte address width of the memory port and of req_addr.
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle and able to accept.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  starting byte address.
- req_wdata  in  32  store data; low byte goes to the lowest address.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores.
- rsp_error  out  1  misaligned request rejected; see Configuration.
- mem_write_enable  out  1  memory write strobe.
- mem_address  out  ADDR_W  memory byte address.
- mem_data_in  out  8  byte to be written to memory.
- mem_data_out  in  8  registered read byte from memory. Updated one edge after the address is driven with write_enable = 0; holds its value while write_enable = 1.

## Operation
- FSM states: IDLE, WRITE, READ, DONE. The request is accepted on a clock edge where req_valid && req_ready; req_ready = (state == IDLE).
- On accept, the controller latches address, size, unsigned flag and wdata. Byte count N = 1/2/4. Byte index i goes to address (req_addr + i) mod 2^ADDR_W, so accesses wrap 1023 -> 0.
- WRITE: for N consecutive cycles, drives mem_write_enable = 1, mem_address = addr+i and mem_data_in = wdata[8i+7:8i]. It then enters DONE.
- READ: for N consecutive cycles, drives mem_address = addr+i with write_enable = 0. This is followed by one drain cycle. Byte i is captured from mem_data_out at the end of the cycle that follows its address cycle. The FSM then enters DONE.
- DONE: rsp_valid = 1 for exactly one cycle, then the FSM returns to IDLE. There is no response backpressure.
- Load extension: byte loads fill bits 31:8 with bit 7 (signed) or 0 (unsigned). Half loads fill bits 31:16 with bit 15 (signed) or 0 (unsigned). Word loads are not extended.
- Outside WRITE, mem_write_enable = 0 and mem_data_in = 0. mem_address holds its last driven value.
- Requests presented while req_ready = 0 are ignored, not queued.
- Reset, including mid-operation: the FSM returns to IDLE and all outputs drop to 0 except req_ready, which goes to 1. No rsp_valid is issued for the aborted request. Bytes already written stay written.

## Timing
- Accept edge = E0. Address/write cycles run in cycles 1..N.
- Store: rsp_valid in cycle N+1, giving a latency of 2 / 3 / 5 cycles for byte / half / word.
- Load: rsp_valid in cycle N+2, giving a latency of 3 / 4 / 6 cycles.
- The next accept can happen at the earliest in the cycle after DONE.
- rsp_rdata and rsp_error are valid only while rsp_valid = 1 and are 0 otherwise.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A half request at an odd address, or a word request with addr[1:0] != 0, performs no memory access.
  - It goes IDLE -> DONE, with rsp_valid and rsp_error = 1 in cycle 1 and rsp_rdata = 0.
- MISALIGN_TRAP_EN undefined:
  - Misaligned requests execute byte-by-byte as normal, including wrap.
  - rsp_error is tied to 0.

## Structure
- Shared package mem_access_pkg holds:
  - the size enum (SIZE_B, SIZE_H, SIZE_W);
  - the state enum;
  - the function size_to_bytes;
  - the constant MEM_BYTES = 1024.
- One sub-module is natural: load_extend, a combinational block mapping assembled bytes, size and unsigned flag to the 32-bit result.

## Test plan
- Word store 0xDEADBEEF at 0x010: memory 0x010..0x013 = EF, BE, AD, DE; rsp_valid in cycle 5, rsp_rdata = 0.
- Then word load at 0x010: rsp_rdata = 0xDEADBEEF, rsp_valid in cycle 6.
- Byte load at 0x012 (0xAD), signed -> 0xFFFFFFAD; unsigned -> 0x000000AD.
- Half load at 0x012, signed: rsp_rdata = 0xFFFFDEAD.
- Word store 0x11223344 at 0x3FE, macro undefined: bytes land at 0x3FE, 0x3FF, 0x000, 0x001. With MISALIGN_TRAP_EN, the same request gives rsp_error = 1 in cycle 1 and memory is unchanged.
- Assert reset in cycle 2 of a word store: byte 0 is written, byte 1 is not, and no rsp_valid is issued. req_ready = 1 in the cycle after reset, and a new request is accepted normally.
